// File: rtl/mux2_1_arb.sv
// rtl/mux2_1_arb.sv - two-source round-robin packet arbiter driving a registered 2:1 mux output stage
// Optional per-source packet counters are enabled by defining MUX_ARB_STATS_EN.
module mux2_1_arb #(
  parameter int DATA_W = 8
`ifdef MUX_ARB_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  input  logic              in2_valid,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_last,
  output logic              in2_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic [CNT_W-1:0]  pkt_cnt2
`endif
);

  typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last2_q, last2_d;  // 1: in2 was served last, so in1 wins a tie
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_free;
  logic              acc1, acc2;

  assign out_free  = ~out_valid_q | out_ready;
  assign in1_ready = (state_q == GNT1) & out_free;
  assign in2_ready = (state_q == GNT2) & out_free;
  assign acc1      = in1_valid & in1_ready;
  assign acc2      = in2_valid & in2_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last2_d = last2_q;
    case (state_q)
      IDLE: begin
        if (in1_valid && (!in2_valid || last2_q)) begin
          state_d = GNT1;
          sel_d   = 1'b1;
        end else if (in2_valid) begin
          state_d = GNT2;
          sel_d   = 1'b0;
        end
      end
      GNT1: begin
        if (acc1 && in1_last) begin
          state_d = IDLE;
          last2_d = 1'b0;
        end
      end
      GNT2: begin
        if (acc2 && in2_last) begin
          state_d = IDLE;
          last2_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the granted source can be accepted, so acc1/acc2 are mutually exclusive.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (acc1) begin
      out_valid_d = 1'b1;
      out_data_d  = in1_data;
      out_last_d  = in1_last;
    end else if (acc2) begin
      out_valid_d = 1'b1;
      out_data_d  = in2_data;
      out_last_d  = in2_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      sel_q       <= 1'b1;
      last2_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last2_q     <= last2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sel       = sel_q;

`ifdef MUX_ARB_STATS_EN
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  // Saturating: stop at all-ones instead of wrapping.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (acc1 && in1_last && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    if (acc2 && in2_last && (cnt2_q != '1)) cnt2_d = cnt2_q + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign pkt_cnt1 = cnt1_q;
  assign pkt_cnt2 = cnt2_q;
`endif

endmodule

// File: tb/tb_mux2_1_arb.sv
// tb/tb_mux2_1_arb.sv - self-checking bench for mux2_1_arb (table vectors plus output scoreboard)
module tb_mux2_1_arb;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       in1_valid, in1_last, in1_ready;
  logic [7:0] in1_data;
  logic       in2_valid, in2_last, in2_ready;
  logic [7:0] in2_data;
  logic       out_valid, out_last, out_ready, sel;
  logic [7:0] out_data;
`ifdef MUX_ARB_STATS_EN
  logic [1:0] pkt_cnt1, pkt_cnt2;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];  // {last, data} in expected output order

  mux2_1_arb #(
    .DATA_W(8)
`ifdef MUX_ARB_STATS_EN
    ,
    .CNT_W(2)
`endif
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in1_valid(in1_valid),
    .in1_data (in1_data),
    .in1_last (in1_last),
    .in1_ready(in1_ready),
    .in2_valid(in2_valid),
    .in2_data (in2_data),
    .in2_last (in2_last),
    .in2_ready(in2_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .sel      (sel)
`ifdef MUX_ARB_STATS_EN
    ,
    .pkt_cnt1 (pkt_cnt1),
    .pkt_cnt2 (pkt_cnt2)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: pops on a handshake, otherwise the held beat must match the queue head.
  always @(negedge sys_clk) begin
    if (!sys_rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("sb_empty", {23'd0, out_last, out_data}, 32'h1ff);
      end else if (out_ready) begin
        chk("out_beat", {23'd0, out_last, out_data}, {23'd0, sb.pop_front()});
      end else begin
        chk("out_hold", {23'd0, out_last, out_data}, {23'd0, sb[0]});
      end
    end
  end

  typedef struct packed {
    logic v1, l1, v2, l2, ordy;
    logic r1, r2, sel, ov;
  } vec_t;

  vec_t tbl[33];
  int   n1 = 0;
  int   n2 = 0;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_one(input int src, input logic [7:0] d);
    step();
    if (src == 1) begin in1_valid = 1'b1; in1_last = 1'b1; in1_data = d; end
    else          begin in2_valid = 1'b1; in2_last = 1'b1; in2_data = d; end
    @(negedge sys_clk);
    step();
    @(negedge sys_clk);
    chk("send_ready", {31'd0, (src == 1) ? in1_ready : in2_ready}, 32'd1);
    sb.push_back({1'b1, d});
    step();
    in1_valid = 1'b0;
    in2_valid = 1'b0;
  endtask

  initial begin
    tbl[0]  = 9'b11111_0010;  // both valid from reset: in1 first
    tbl[1]  = 9'b11111_1010;
    tbl[2]  = 9'b11111_0011;
    tbl[3]  = 9'b11111_0100;
    tbl[4]  = 9'b11111_0001;
    tbl[5]  = 9'b11111_1010;
    tbl[6]  = 9'b11111_0011;
    tbl[7]  = 9'b11111_0100;
    tbl[8]  = 9'b10001_0001;  // in1 three-beat packet
    tbl[9]  = 9'b10001_1010;
    tbl[10] = 9'b10001_1011;
    tbl[11] = 9'b11001_1011;
    tbl[12] = 9'b00101_0011;  // in2 four-beat packet, in1 contends mid-packet
    tbl[13] = 9'b00101_0100;
    tbl[14] = 9'b00101_0101;
    tbl[15] = 9'b11101_0101;
    tbl[16] = 9'b11111_0101;
    tbl[17] = 9'b11001_0001;
    tbl[18] = 9'b11001_1010;
    tbl[19] = 9'b00101_0011;  // in2 packet with 5-cycle stall and a valid gap
    tbl[20] = 9'b00101_0100;
    tbl[21] = 9'b00100_0001;
    tbl[22] = 9'b00100_0001;
    tbl[23] = 9'b00100_0001;
    tbl[24] = 9'b00100_0001;
    tbl[25] = 9'b00100_0001;
    tbl[26] = 9'b00101_0101;
    tbl[27] = 9'b00001_0101;
    tbl[28] = 9'b11001_0100;
    tbl[29] = 9'b11101_0100;
    tbl[30] = 9'b11111_0101;
    tbl[31] = 9'b00001_0001;
    tbl[32] = 9'b00001_0000;

    sys_rst   = 1'b1;
    in1_valid = 1'b0; in1_last = 1'b0; in1_data = 8'h00;
    in2_valid = 1'b0; in2_last = 1'b0; in2_data = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_sel", {31'd0, sel}, 32'd1);
    chk("rst_ready", {30'd0, in1_ready, in2_ready}, 32'd0);

    for (int i = 0; i < 33; i++) begin
      step();
      if (i == 0) sys_rst = 1'b0;
      in1_valid = tbl[i].v1;
      in1_last  = tbl[i].l1;
      in2_valid = tbl[i].v2;
      in2_last  = tbl[i].l2;
      out_ready = tbl[i].ordy;
      in1_data  = 8'h10 + n1[7:0];
      in2_data  = 8'h80 + n2[7:0];
      if (tbl[i].r1 && tbl[i].v1) begin sb.push_back({tbl[i].l1, in1_data}); n1++; end
      if (tbl[i].r2 && tbl[i].v2) begin sb.push_back({tbl[i].l2, in2_data}); n2++; end
      @(negedge sys_clk);
      chk($sformatf("row%0d_in1_ready", i), {31'd0, in1_ready}, {31'd0, tbl[i].r1});
      chk($sformatf("row%0d_in2_ready", i), {31'd0, in2_ready}, {31'd0, tbl[i].r2});
      chk($sformatf("row%0d_sel", i), {31'd0, sel}, {31'd0, tbl[i].sel});
      chk($sformatf("row%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
    end

    // Async reset in the middle of an in1 packet.
    step();
    in1_valid = 1'b0; in2_valid = 1'b0; out_ready = 1'b1;
    step();
    in1_valid = 1'b1; in1_last = 1'b0; in1_data = 8'h55;
    @(negedge sys_clk);
    step();
    @(negedge sys_clk);
    chk("mid_in1_ready", {31'd0, in1_ready}, 32'd1);
    sb.push_back({1'b0, 8'h55});
    step();
    in1_data = 8'h56;
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_sel", {31'd0, sel}, 32'd1);
    chk("arst_in1_ready", {31'd0, in1_ready}, 32'd0);
    sb.delete();
    in1_valid = 1'b0;
    step();
    sys_rst   = 1'b0;
    in1_valid = 1'b1; in1_last = 1'b1; in1_data = 8'h66;
    in2_valid = 1'b1; in2_last = 1'b1; in2_data = 8'h99;
    @(negedge sys_clk);
    step();
    @(negedge sys_clk);
    chk("post_rst_in1_ready", {31'd0, in1_ready}, 32'd1);
    chk("post_rst_in2_ready", {31'd0, in2_ready}, 32'd0);
    chk("post_rst_sel", {31'd0, sel}, 32'd1);
    sb.push_back({1'b1, 8'h66});
    step();
    in1_valid = 1'b0; in2_valid = 1'b0;
    repeat (2) step();

`ifdef MUX_ARB_STATS_EN
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("cnt_rst", {28'd0, pkt_cnt1, pkt_cnt2}, 32'd0);
    sb.delete();
    step();
    sys_rst = 1'b0;
    for (int k = 0; k < 5; k++) send_one(1, 8'hc0 + k[7:0]);
    send_one(2, 8'hd0);
    repeat (2) step();
    @(negedge sys_clk);
    chk("pkt_cnt1_sat", {30'd0, pkt_cnt1}, 32'd3);
    chk("pkt_cnt2", {30'd0, pkt_cnt2}, 32'd1);
`else
    send_one(2, 8'hd0);
    send_one(1, 8'hc0);
`endif

    repeat (3) step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
